// File: rtl/imm_encoder_pkg.sv
// Shared immediate-encoding definitions: ImmSrc codes and encoder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_encoder_pkg;

    // ImmSrc codes, common to the extender, the control decoder and the encoder.
    typedef logic [1:0] imm_src_t;

    localparam imm_src_t IMM_ROT = 2'b00;  // rotated imm8
    localparam imm_src_t IMM_12  = 2'b01;  // zero-extended imm12
    localparam imm_src_t IMM_BR  = 2'b10;  // branch word offset

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle between an instruction builder and imm_encoder.
// Latency: n/a (wires only).
// Backpressure: none; the requester watches Busy and Start is dropped while Busy.
// master = requester (drives Start/ImmSrc/Value); slave = encoder (drives results).
interface imm_encoder_if;
    import imm_encoder_pkg::*;

    logic        Start;
    imm_src_t    ImmSrc;
    logic [31:0] Value;
    logic        Busy;
    logic        Done;
    logic        Valid;
    logic [23:0] InstrImm;

    modport master (output Start, ImmSrc, Value,
                    input  Busy, Done, Valid, InstrImm);
    modport slave  (input  Start, ImmSrc, Value,
                    output Busy, Done, Valid, InstrImm);
endinterface

// File: rtl/imm_encoder_rot_check.sv
// Tests one rotation candidate: ROL(value, 2*rot) fits in 8 bits?
// Latency: combinational.
// Backpressure: n/a.
// Ports: value_i (constant), rot_i (rotation index), match_o, imm8_o.
module imm_rot_check (
    input  logic [31:0] value_i,
    input  logic [3:0]  rot_i,
    output logic        match_o,
    output logic [7:0]  imm8_o
);
    logic [5:0]  sh;
    logic [31:0] t;

    always_comb begin
        sh = {1'b0, rot_i, 1'b0};
        // A shift by 32 (sh == 0) yields zero, so sh == 0 reduces to t = value_i.
        t  = (value_i << sh) | (value_i >> (6'd32 - sh));
        match_o = (t[31:8] == 24'd0);
        imm8_o  = t[7:0];
    end
endmodule

// File: rtl/imm_encoder.sv
// Inverse immediate extender: turns a 32-bit constant into the 24-bit InstrImm field.
// Latency: Done after edge 1 (modes 01/10/11), edge r+2 (rotated hit at r), edge 17 (no hit).
// Backpressure: Start is taken only in IDLE; requests arriving while searching are dropped.
// Ports: CLK, RESETn (async active-low), bus (slave: Start/ImmSrc/Value in, Busy/Done/Valid/InstrImm out).
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic         CLK,
    input  logic         RESETn,
    imm_encoder_if.slave bus
);
    state_e      state_q, state_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] value_q, value_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [23:0] imm_q, imm_d;

    logic        rc_match;
    logic [7:0]  rc_imm8;
    logic        imm12_ok;
    logic        br_ok;

    imm_rot_check u_rot_check (
        .value_i (value_q),
        .rot_i   (rot_q),
        .match_o (rc_match),
        .imm8_o  (rc_imm8)
    );

    // Direct modes are judged on the incoming Value in the accepting cycle.
    assign imm12_ok = (bus.Value[31:12] == 20'd0);
    // Branch offset: word aligned and bits 31:26 are the sign extension of bit 25.
    assign br_ok    = (bus.Value[1:0] == 2'b00) &&
                      ((bus.Value[31:25] == 7'h00) || (bus.Value[31:25] == 7'h7F));

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        // Done is the registered echo of the one DONE cycle, so it lands one edge later.
        done_d  = (state_q == DONE);

        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    value_d = bus.Value;
                    rot_d   = 4'd0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    case (bus.ImmSrc)
                        IMM_ROT: state_d = SEARCH;
                        IMM_12: begin
                            valid_d = imm12_ok;
                            imm_d   = imm12_ok ? {12'd0, bus.Value[11:0]} : 24'd0;
                            state_d = DONE;
                        end
                        IMM_BR: begin
                            valid_d = br_ok;
                            imm_d   = br_ok ? bus.Value[25:2] : 24'd0;
                            state_d = DONE;
                        end
                        default: begin
                            valid_d = 1'b0;
                            imm_d   = 24'd0;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            SEARCH: begin
                // Rotations are tried in ascending order, so the first hit is canonical.
                if (rc_match) begin
                    valid_d = 1'b1;
                    imm_d   = {12'd0, rot_q, rc_imm8};
                    state_d = DONE;
                end else if (rot_q == 4'd15) begin
                    valid_d = 1'b0;
                    imm_d   = 24'd0;
                    state_d = DONE;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            rot_q   <= 4'd0;
            value_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            imm_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Valid    = valid_q;
    assign bus.InstrImm = imm_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: scoreboard of expected results from an extender model.
// Latency: n/a.
// Backpressure: requests are issued only while the encoder is idle, except the drop test.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    imm_encoder_if bus ();

    imm_encoder dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  mode;
        logic        valid;
        logic [23:0] imm;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference extender: decodes an InstrImm field back to a 32-bit constant.
    function automatic logic [31:0] extend(input logic [1:0] mode, input logic [23:0] imm);
        case (mode)
            2'b00:   return ror32({24'd0, imm[7:0]}, 2 * int'(imm[11:8]));
            2'b01:   return {20'd0, imm[11:0]};
            2'b10:   return {{6{imm[23]}}, imm, 2'b00};
            default: return 32'd0;
        endcase
    endfunction

    // Expected result built by searching the extender's input space.
    task automatic push_exp(input logic [1:0] mode, input logic [31:0] v, input string name);
        exp_t e;
        bit found;
        e.value = v; e.mode = mode; e.valid = 1'b0; e.imm = 24'd0; e.lat = 1; e.name = name;
        case (mode)
            2'b00: begin
                e.lat = 17;
                found = 1'b0;
                for (int r = 0; r < 16; r++) begin
                    for (int i = 0; i < 256; i++) begin
                        if (!found && ror32(32'(i), 2 * r) == v) begin
                            found = 1'b1;
                            e.valid = 1'b1;
                            e.imm = {12'd0, 4'(r), 8'(i)};
                            e.lat = r + 2;
                        end
                    end
                end
            end
            2'b01: if (v < 32'd4096) begin e.valid = 1'b1; e.imm = {12'd0, v[11:0]}; end
            2'b10: if (extend(2'b10, v[25:2]) == v) begin e.valid = 1'b1; e.imm = v[25:2]; end
            default: ;
        endcase
        sb.push_back(e);
    endtask

    // Present Start for exactly one edge (edge 0); returns #1 after that edge.
    task automatic drive_start(input logic [1:0] mode, input logic [31:0] v);
        bus.ImmSrc = mode;
        bus.Value  = v;
        bus.Start  = 1'b1;
        @(posedge CLK); #1;
        bus.Start  = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int n;
        bit seen;
        exp_t e;
        n = n0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge CLK); #1;
            n++;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: Done observed=%0b with no expected entry", seen);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: Done not seen by edge %0d, required at edge %0d", e.name, n, e.lat);
            return;
        end
        checks++;
        if (n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: Done at edge %0d, required edge %0d", e.name, n, e.lat);
        end
        checks++;
        if (bus.Valid !== e.valid) begin
            errors++;
            $display("FAIL %s valid: got %0b, required %0b", e.name, bus.Valid, e.valid);
        end
        checks++;
        if (bus.InstrImm !== e.imm) begin
            errors++;
            $display("FAIL %s instrimm: got %06h, required %06h", e.name, bus.InstrImm, e.imm);
        end
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_with_done: got %0b, required 1", e.name, bus.Busy);
        end
        if (e.valid) begin
            checks++;
            if (extend(e.mode, bus.InstrImm) !== e.value) begin
                errors++;
                $display("FAIL %s roundtrip: extends to %08h, required %08h",
                         e.name, extend(e.mode, bus.InstrImm), e.value);
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_end: Done=%0b Busy=%0b, required 0/0", e.name, bus.Done, bus.Busy);
        end
    endtask

    task automatic run_req(input logic [1:0] mode, input logic [31:0] v, input string name);
        push_exp(mode, v, name);
        drive_start(mode, v);
        wait_done(0);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Valid !== 1'b0 || bus.InstrImm !== 24'd0) begin
            errors++;
            $display("FAIL %s outputs: Busy=%0b Done=%0b Valid=%0b InstrImm=%06h, required all 0",
                     name, bus.Busy, bus.Done, bus.Valid, bus.InstrImm);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL %s state: got %0d, required IDLE", name, dut.state_q);
        end
    endtask

    task automatic test_reset();
        #2;
        check_idle_outputs("reset");
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        check_idle_outputs("after_reset");
    endtask

    task automatic test_rot();
        run_req(IMM_ROT, 32'h000000FF, "rot_ff");
        run_req(IMM_ROT, 32'hFF000000, "rot_ff000000");
        run_req(IMM_ROT, 32'hF000000F, "rot_f000000f");
        run_req(IMM_ROT, 32'h00000102, "rot_nomatch");
        run_req(IMM_ROT, 32'h00000000, "rot_zero");
        run_req(IMM_ROT, 32'h000003FC, "rot_3fc");
    endtask

    task automatic test_imm12();
        run_req(IMM_12, 32'h00000ABC, "imm12_abc");
        run_req(IMM_12, 32'h00001000, "imm12_over");
        run_req(IMM_12, 32'h00000FFF, "imm12_max");
    endtask

    task automatic test_branch();
        run_req(IMM_BR, 32'hFFFFFFF8, "br_neg");
        run_req(IMM_BR, 32'h00000006, "br_misaligned");
        run_req(IMM_BR, 32'h04000000, "br_range");
        run_req(IMM_BR, 32'h03FFFFFC, "br_posmax");
    endtask

    task automatic test_reserved();
        run_req(2'b11, 32'h00000005, "reserved");
    endtask

    task automatic test_busy_ignore();
        bit stray;
        push_exp(IMM_ROT, 32'hFF000000, "busy_ignore");
        drive_start(IMM_ROT, 32'hFF000000);
        bus.ImmSrc = IMM_ROT;
        bus.Value  = 32'h000000FF;
        bus.Start  = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.Start  = 1'b0;
        wait_done(2);
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL busy_ignore_stray: extra activity seen=%0b, required 0", stray);
        end
    endtask

    task automatic test_reset_mid_search();
        bit stray;
        drive_start(IMM_ROT, 32'h00000102);
        repeat (4) begin @(posedge CLK); #1; end
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy: got %0b, required 1", bus.Busy);
        end
        RESETn = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge CLK);
        RESETn = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK); #1;
            if (bus.Done === 1'b1) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL midreset_no_done: Done seen=%0b, required 0", stray);
        end
        run_req(IMM_ROT, 32'h00003FC0, "after_midreset");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  m;
        logic [31:0] v;
        for (int k = 0; k < 10; k++) begin
            m = 2'($urandom_range(0, 3));
            if (k % 3 == 0) v = $urandom();
            else if (m == IMM_ROT) v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            else if (m == IMM_BR) v = {{6{v[25]}}, 26'($urandom()) & 26'h3FFFFFC};
            else v = 32'($urandom_range(0, 8191));
            run_req(m, v, $sformatf("b2b_%0d", k));
        end
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.ImmSrc = 2'b00;
        bus.Value  = 32'd0;
        test_reset();
        test_rot();
        test_imm12();
        test_branch();
        test_reserved();
        test_busy_ignore();
        test_reset_mid_search();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
